// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory/IO controller.
package lc3_mem_pkg;

  localparam int          SRAM_ADDR_W     = 20;
  localparam int          DATA_W          = 16;
  localparam int          CNT_W           = 3;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_DONE
  } mem_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous board switches.
// Only built when LC3_MEM_IO_EN is defined; without the IO decode there
// is nothing to synchronize.
`ifdef LC3_MEM_IO_EN
module sync2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability filter: first flop may go metastable, second resolves it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`endif

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: sequences the external async SRAM strobes
// from the control unit's level-held Mem_OE/Mem_WE, and decodes one
// memory-mapped IO address (switches on read, hex display on write).
// Build option: define LC3_MEM_IO_EN to enable the IO_ADDR decode,
// the switch synchronizer and the Hex_Data register.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic [DATA_W-1:0]      MAR,
  input  logic [DATA_W-1:0]      MDR,
  input  logic [DATA_W-1:0]      Switches,
  output logic [DATA_W-1:0]      Data_to_CPU,
  output logic                   Mem_Ready,
  output logic [DATA_W-1:0]      Hex_Data,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0]      SRAM_DQ_in,
  output logic [DATA_W-1:0]      SRAM_DQ_out,
  output logic                   SRAM_DQ_oe
);

  // Strobe-low duration counts down from WAIT_CYCLES-1 to 0.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

`ifdef LC3_MEM_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] hex_q, hex_d;
  logic              is_io_q, is_io_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] sw_sync;
  logic              io_hit;

`ifdef LC3_MEM_IO_EN
  sync2 #(
    .WIDTH (DATA_W)
  ) u_sw_sync (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .d_i    (Switches),
    .q_o    (sw_sync)
  );
`else
  logic unused_switches;
  assign unused_switches = ^Switches;
  assign sw_sync         = '0;
`endif

  // Without the decode, IO_ADDR is just another SRAM location.
  assign io_hit = IO_EN && (MAR == IO_ADDR);

  // Next-state, capture and registered-strobe decode for the access FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    data_d  = data_q;
    hex_d   = hex_q;
    is_io_d = is_io_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ready_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A write wins when both requests are raised together.
        if (Mem_WE) begin
          state_d = WR_SETUP;
          addr_d  = MAR;
          mdr_d   = MDR;
          is_io_d = io_hit;
        end else if (Mem_OE) begin
          state_d = RD;
          addr_d  = MAR;
          is_io_d = io_hit;
          cnt_d   = WAIT_LOAD;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          state_d = RD_DONE;
          data_d  = is_io_q ? sw_sync : SRAM_DQ_in;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DONE: begin
        // Request must drop before a new access can start.
        if (!Mem_OE) state_d = IDLE;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WAIT_LOAD;
        if (is_io_q) hex_d = mdr_q;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_DONE;
        else             cnt_d   = cnt_q - 3'd1;
      end
      WR_DONE: begin
        if (!Mem_WE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered off the next state so they align with it;
    // IO accesses run the same sequence with every SRAM strobe held high.
    unique case (state_d)
      RD: begin
        ce_n_d = is_io_d;
        oe_n_d = is_io_d;
      end
      RD_DONE: begin
        ready_d = (state_q == RD);
      end
      WR_SETUP: begin
        ce_n_d  = is_io_d;
        dq_oe_d = !is_io_d;
      end
      WR_PULSE: begin
        ce_n_d  = is_io_d;
        we_n_d  = is_io_d;
        dq_oe_d = !is_io_d;
      end
      WR_DONE: begin
        // First cycle only: keep data driven past WE_N rising for hold time.
        if (state_q == WR_PULSE) begin
          ce_n_d  = is_io_d;
          dq_oe_d = !is_io_d;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, capture and output registers; reset forces strobes high at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      data_q  <= '0;
      hex_q   <= '0;
      is_io_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      data_q  <= data_d;
      hex_q   <= hex_d;
      is_io_q <= is_io_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      ready_q <= ready_d;
    end
  end

  assign Data_to_CPU = data_q;
  assign Mem_Ready   = ready_q;
  assign Hex_Data    = IO_EN ? hex_q : '0;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = ce_n_q;
  assign SRAM_LB_N   = ce_n_q;
  assign SRAM_ADDR   = {4'b0000, addr_q};
  assign SRAM_DQ_out = mdr_q;
  assign SRAM_DQ_oe  = dq_oe_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl with a behavioural async SRAM model.
module tb_lc3_mem_ctrl;

  localparam int WC  = 1;
  localparam int WIN = 12;

  logic        Clk;
  logic        Reset;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;
  logic [15:0] Hex_Data;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb[$];
  logic [15:0] mem [0:65535];

  lc3_mem_ctrl #(
    .WAIT_CYCLES (WC),
    .IO_ADDR     (16'hFFFF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Mem_OE      (Mem_OE),
    .Mem_WE      (Mem_WE),
    .MAR         (MAR),
    .MDR         (MDR),
    .Switches    (Switches),
    .Data_to_CPU (Data_to_CPU),
    .Mem_Ready   (Mem_Ready),
    .Hex_Data    (Hex_Data),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_in  (SRAM_DQ_in),
    .SRAM_DQ_out (SRAM_DQ_out),
    .SRAM_DQ_oe  (SRAM_DQ_oe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: combinational read, write on a clock edge while WE_N low.
  assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[15:0]] : 16'h0000;
  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe)
      mem[SRAM_ADDR[15:0]] <= SRAM_DQ_out;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] rng(input int lo, input int hi);
    logic [15:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // One access: request raised in cycle 0, dropped in cycle 'hold'.
  // Per-cycle strobe activity is recorded and compared to the expected timing.
  task automatic access(input bit wr, input bit both, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rexp,
                        input int hold, input bit io, input string tag);
    logic [15:0] ce_m, oe_m, we_m, ub_m, dqoe_m, rdy_m;
    logic [15:0] e_ce, e_oe, e_we, e_dqoe, e_rdy;
    ce_m = '0; oe_m = '0; we_m = '0; ub_m = '0; dqoe_m = '0; rdy_m = '0;
    if (!wr) sb.push_back(rexp);
    MAR    = addr;
    MDR    = wdata;
    Mem_WE = wr;
    Mem_OE = !wr || both;
    for (int k = 0; k < WIN; k++) begin
      if (k > 0) begin
        @(posedge Clk);
        #1;
      end
      if (k == hold) begin
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
      end
      if (!SRAM_CE_N) ce_m[k] = 1'b1;
      if (!SRAM_OE_N) oe_m[k] = 1'b1;
      if (!SRAM_WE_N) we_m[k] = 1'b1;
      if (!SRAM_UB_N && !SRAM_LB_N) ub_m[k] = 1'b1;
      if (SRAM_DQ_oe) dqoe_m[k] = 1'b1;
      if (Mem_Ready) begin
        rdy_m[k] = 1'b1;
        if (!wr) begin
          check({tag, "_sb_depth"}, sb.size(), 1);
          if (sb.size() > 0) check({tag, "_rdata"}, Data_to_CPU, sb.pop_front());
        end
      end
    end
    if (wr) begin
      e_ce   = io ? 16'h0 : rng(1, WC + 2);
      e_oe   = 16'h0;
      e_we   = io ? 16'h0 : rng(2, WC + 1);
      e_dqoe = io ? 16'h0 : rng(1, WC + 2);
      e_rdy  = rng(WC + 2, WC + 2);
    end else begin
      e_ce   = io ? 16'h0 : rng(1, WC);
      e_oe   = e_ce;
      e_we   = 16'h0;
      e_dqoe = 16'h0;
      e_rdy  = rng(WC + 1, WC + 1);
    end
    check({tag, "_ce"},    ce_m,   e_ce);
    check({tag, "_oe"},    oe_m,   e_oe);
    check({tag, "_we"},    we_m,   e_we);
    check({tag, "_ublb"},  ub_m,   e_ce);
    check({tag, "_dqoe"},  dqoe_m, e_dqoe);
    check({tag, "_ready"}, rdy_m,  e_rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic rdy_seen, we_seen;
    mem[16'h1234] = 16'h1111;
    mem[16'h0042] = 16'hBEEF;
    mem[16'h0100] = 16'h0000;
    mem[16'h0010] = 16'h0000;
    mem[16'hFFFF] = 16'h0000;
    mem[16'h0200] = 16'h0BAD;
    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
    MAR = '0; MDR = '0; Switches = '0;
    #2;
    // Reset held with a read request pending.
    Reset  = 1'b0;
    MAR    = 16'h1234;
    Mem_OE = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("rst_addr",  SRAM_ADDR,   20'h0);
    check("rst_dqout", SRAM_DQ_out, 16'h0);
    check("rst_dqoe",  SRAM_DQ_oe,  1'b0);
    check("rst_data",  Data_to_CPU, 16'h0);
    check("rst_ready", Mem_Ready,   1'b0);
    check("rst_hex",   Hex_Data,    16'h0);
    Reset = 1'b1;
    access(1'b0, 1'b0, 16'h1234, 16'h0, 16'h1111, 3, 1'b0, "post_rst_rd");

    access(1'b0, 1'b0, 16'h0042, 16'h0, 16'hBEEF, 3, 1'b0, "rd_beef");
    check("rd_addr", SRAM_ADDR, 20'h00042);

    access(1'b1, 1'b0, 16'h0100, 16'hA5A5, 16'h0, 3, 1'b0, "wr_a5a5");
    check("rd_data_hold", Data_to_CPU, 16'hBEEF);
    check("wr_mem", mem[16'h0100], 16'hA5A5);
    access(1'b0, 1'b0, 16'h0100, 16'h0, 16'hA5A5, 3, 1'b0, "rb_a5a5");

    // Both requests high: write wins, OE_N never low.
    access(1'b1, 1'b1, 16'h0010, 16'h7777, 16'h0, 3, 1'b0, "both");
    access(1'b0, 1'b0, 16'h0010, 16'h0, 16'h7777, 3, 1'b0, "rb_7777");

    // Request held well past completion must not retrigger.
    access(1'b0, 1'b0, 16'h0042, 16'h0, 16'hBEEF, 7, 1'b0, "hold_long");

`ifdef LC3_MEM_IO_EN
    access(1'b1, 1'b0, 16'hFFFF, 16'h00FF, 16'h0, 3, 1'b1, "io_wr");
    check("io_hex", Hex_Data, 16'h00FF);
    check("io_mem_untouched", mem[16'hFFFF], 16'h0000);
    Switches = 16'h0003;
    repeat (3) @(posedge Clk);
    #1;
    access(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h0003, 3, 1'b1, "io_rd");
`else
    access(1'b1, 1'b0, 16'hFFFF, 16'h00FF, 16'h0, 3, 1'b0, "ffff_wr");
    check("hex_tied0", Hex_Data, 16'h0);
    Switches = 16'h0003;
    access(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h00FF, 3, 1'b0, "ffff_rd");
`endif

    // Reset pulsed during WR_PULSE.
    MAR = 16'h0200; MDR = 16'h5555; Mem_WE = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("rstwr_we_low", SRAM_WE_N, 1'b0);
    #1 Reset = 1'b0;
    #1;
    check("rstwr_we_async", SRAM_WE_N, 1'b1);
    check("rstwr_ce_async", SRAM_CE_N, 1'b1);
    check("rstwr_dqoe_async", SRAM_DQ_oe, 1'b0);
    Mem_WE = 1'b0;
    rdy_seen = Mem_Ready;
    we_seen  = !SRAM_WE_N;
    @(posedge Clk); #1;
    Reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (Mem_Ready) rdy_seen = 1'b1;
      if (!SRAM_WE_N) we_seen = 1'b1;
      @(posedge Clk); #1;
    end
    check("rstwr_no_ready", rdy_seen, 1'b0);
    check("rstwr_no_we", we_seen, 1'b0);
    access(1'b0, 1'b0, 16'h0042, 16'h0, 16'hBEEF, 3, 1'b0, "rstwr_idle_rd");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
